sdram_arb: RTL

SDRAM_ARB -- requirements
Module: sdram_arb

---
 rtl/sdram_arb.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/sdram_arb.sv
// ---------------------------------------------------------------------------
// sdram_arb
//
// Arbitrates a single SDRAM command port between the ROM download path and
// three level-sensitive read requesters (CPU, GFX, sound).  Download bytes
// are packed big-endian into 16-bit words and queued as a one-entry pending
// write.  A pending write always beats reads.  Reads are granted round-robin
// and are held off while a download is in progress.  Only one memory access
// is outstanding at a time.
//
// Ports
//   clk_sys        single rising-edge clock
//   reset_n        asynchronous active-low reset
//   rom_download   download in progress
//   ioctl_wr       one-cycle download byte strobe
//   ioctl_addr     download byte address
//   ioctl_dout     download byte
//   rd_req         level read request per requester {sound, gfx, cpu}
//   rd_addr        word address per requester, packed {r2, r1, r0}
//   rd_ack         one-cycle pulse: rd_data valid for that requester
//   rd_data        shared read data
//   mem_req        command valid towards the SDRAM controller
//   mem_we         command is a write
//   mem_addr       command word address
//   mem_din        write data
//   mem_ready      controller accepts the command this cycle
//   mem_valid      read data strobe from the controller
//   mem_dout       read data from the controller
//   rom_loaded     download finished and every word written
//   busy           access in progress or write pending
//   overflow       a download word was dropped (sticky until reset)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no access; choose pending write, else a round-robin read
// WR_ISSUE | presenting the pending write until mem_ready
// RD_ISSUE | presenting the granted read address until mem_ready
// RD_WAIT  | read accepted, waiting for mem_valid
// ---------------------------------------------------------------------------
module sdram_arb #(
    parameter int AW = 24
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              rom_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [2:0]        rd_req,
    input  logic [3*AW-1:0]   rd_addr,
    output logic [2:0]        rd_ack,
    output logic [15:0]       rd_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [15:0]       mem_din,
    input  logic              mem_ready,
    input  logic              mem_valid,
    input  logic [15:0]       mem_dout,
    output logic              rom_loaded,
    output logic              busy,
    output logic              overflow
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_ISSUE = 2'd1,
        RD_ISSUE = 2'd2,
        RD_WAIT  = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [1:0]      grant, grant_nxt;
    logic [1:0]      rr_ptr, rr_nxt;
    logic            ack_set;

    logic [7:0]      hi_byte;
    logic            wr_pend;
    logic [AW-1:0]   wr_addr;
    logic [15:0]     wr_data;
    logic            dl_q;
    logic            load_armed;

    logic [2:0]      elig;
    logic [2:0]      idx3;
    logic            found;
    logic [1:0]      pick;
    logic [AW-1:0]   rd_addr_sel;
    logic            wr_xfer;
    logic            odd_wr;

    assign wr_xfer = (state == WR_ISSUE) && mem_ready;
    assign odd_wr  = ioctl_wr && ioctl_addr[0];
    assign busy    = (state != IDLE) || wr_pend;

    always_comb begin
        rd_addr_sel = '0;
        case (grant)
            2'd0:    rd_addr_sel = rd_addr[AW-1:0];
            2'd1:    rd_addr_sel = rd_addr[2*AW-1:AW];
            2'd2:    rd_addr_sel = rd_addr[3*AW-1:2*AW];
            default: rd_addr_sel = '0;
        endcase
    end

    // A requester whose ack is on the wire this cycle is not eligible, so a
    // level request held through its ack does not get a duplicate grant.
    always_comb begin
        elig  = rd_req & ~rd_ack;
        found = 1'b0;
        pick  = 2'd0;
        idx3  = 3'd0;
        for (int i = 0; i < 3; i++) begin
            idx3 = {1'b0, rr_ptr} + 3'(i);
            if (idx3 >= 3'd3) begin
                idx3 = idx3 - 3'd3;
            end
            if (!found && elig[idx3[1:0]]) begin
                found = 1'b1;
                pick  = idx3[1:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        rr_nxt    = rr_ptr;
        ack_set   = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_din   = '0;
        case (state)
            IDLE: begin
                if (wr_pend) begin
                    state_nxt = WR_ISSUE;
                end else if (!rom_download && found) begin
                    state_nxt = RD_ISSUE;
                    grant_nxt = pick;
                    rr_nxt    = (pick == 2'd2) ? 2'd0 : pick + 2'd1;
                end
            end
            WR_ISSUE: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = wr_addr;
                mem_din  = wr_data;
                if (mem_ready) begin
                    state_nxt = IDLE;
                end
            end
            RD_ISSUE: begin
                mem_req  = 1'b1;
                mem_addr = rd_addr_sel;
                if (mem_ready) begin
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (mem_valid) begin
                    ack_set   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            grant   <= 2'd0;
            rr_ptr  <= 2'd0;
            rd_ack  <= 3'b000;
            rd_data <= 16'h0000;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            rr_ptr  <= rr_nxt;
            rd_ack  <= ack_set ? (3'b001 << grant) : 3'b000;
            if (ack_set) begin
                rd_data <= mem_dout;
            end
        end
    end

    // Download packing and the one-entry write slot.  An odd byte landing on
    // the edge the slot empties simply refills it; otherwise a full slot
    // drops the new word and flags overflow.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hi_byte  <= 8'h00;
            wr_pend  <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 16'h0000;
            overflow <= 1'b0;
        end else begin
            if (ioctl_wr && !ioctl_addr[0]) begin
                hi_byte <= ioctl_dout;
            end
            if (odd_wr) begin
                if (!wr_pend || wr_xfer) begin
                    wr_pend <= 1'b1;
                    wr_addr <= ioctl_addr[AW:1];
                    wr_data <= {hi_byte, ioctl_dout};
                end else begin
                    overflow <= 1'b1;
                end
            end else if (wr_xfer) begin
                wr_pend <= 1'b0;
            end
        end
    end

    // rom_loaded: cleared when a download starts, armed when it ends, and
    // set once the last queued word has gone out.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dl_q       <= 1'b0;
            load_armed <= 1'b0;
            rom_loaded <= 1'b0;
        end else begin
            dl_q <= rom_download;
            if (rom_download && !dl_q) begin
                rom_loaded <= 1'b0;
                load_armed <= 1'b0;
            end else if (!rom_download && dl_q) begin
                load_armed <= 1'b1;
            end else if (load_armed && !rom_download && !wr_pend) begin
                rom_loaded <= 1'b1;
                load_armed <= 1'b0;
            end
        end
    end

endmodule
